mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  input  1  single clock; all state updates on the falling edge of CLK, matching the pipeline registers.
REQ-002 Rst  input  1  reset, synchronous, active-high, sampled on the falling edge of CLK.
REQ-003 M_ALUout  input  32  EX/MEM ALU result; data memory byte address for loads and stores.
REQ-004 M_busB  input  32  EX/MEM store data.
REQ-005 M_Btarg  input  32  EX/MEM branch target.
REQ-006 M_Jtarg  input  32  EX/MEM jump target.
REQ-007 M_Zero  input  1  EX/MEM ALU zero flag.
REQ-008 M_Overflow  input  1  EX/MEM ALU overflow flag.
REQ-009 M_Rw  input  5  EX/MEM destination register.
REQ-010 M_MemWr  input  1  store request.
REQ-011 M_Jump  input  1  jump instruction.
REQ-012 M_Branch  input  1  conditional branch instruction.
REQ-013 M_MemtoReg  input  1  writeback selects memory data.
REQ-014 M_RegWr  input  1  register write enable.
REQ-015 D_Addr  output  32  data memory address, equals {M_ALUout[31:2],2'b00}.
REQ-016 D_Wdata  output  32  data memory write data, equals M_busB.
REQ-017 D_We  output  1  write strobe, valid only while D_Req=1.
REQ-018 D_Req  output  1  access request, held until D_Ack is seen.
REQ-019 D_Rdata  input  32  read data, valid in the cycle D_Ack=1.
REQ-020 D_Ack  input  1  memory completion, single-cycle pulse.
REQ-021 Stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-022 PCSrc  output  1  redirect PC and flush younger stages.
REQ-023 PC_targ  output  32  redirect target.
REQ-024 W_Data  output  32  MEM/WB writeback data.
REQ-025 W_Rw  output  5  MEM/WB destination register.
REQ-026 W_RegWr  output  1  MEM/WB register write enable.
REQ-027 Mem_Err  output  1  sticky access-timeout flag.

Function
REQ-028 Definitions: ld = M_MemtoReg & M_RegWr & ~M_Overflow; st = M_MemWr & ~M_Overflow; op = ld | st.
REQ-029 FSM states: IDLE, WAIT, DONE; D_Req = op in IDLE or WAIT, else 0; D_We = st & D_Req.
REQ-030 Transitions: IDLE->WAIT on op & ~D_Ack; IDLE->DONE on op & D_Ack; WAIT->DONE on D_Ack; DONE->IDLE unconditionally; IDLE with ~op stays IDLE.
REQ-031 On the edge where D_Ack=1 and ld=1, D_Rdata is captured into an internal 32-bit buffer; any D_Ack seen in IDLE with ~op, or in DONE, is ignored.
REQ-032 Stall = op & (state != DONE), combinational; a memory op therefore stalls for at least 1 cycle, and for n+1 cycles when D_Ack arrives n cycles after the request.
REQ-033 On each edge with Stall=0: W_Data <= (M_MemtoReg ? buffer : M_ALUout); W_Rw <= M_Rw; W_RegWr <= M_RegWr & ~M_Overflow.
REQ-034 On each edge with Stall=1: W_RegWr <= 0 to insert a bubble; W_Data and W_Rw hold their values.
REQ-035 PCSrc = ~Stall & (M_Jump | (M_Branch & M_Zero)); PC_targ = M_Jump ? M_Jtarg : M_Btarg; M_Jump takes priority when M_Jump and M_Branch are both 1.
REQ-036 An overflowing instruction performs no memory access and no register write.

Reset
REQ-037 Rst=1 at the falling edge of CLK: state <= IDLE, buffer, W_Data <= 0, W_Rw <= 0, W_RegWr <= 0, Mem_Err <= 0, timeout counter <= 0; Rst overrides any in-flight access, and a late D_Ack after reset is ignored unless a new op is pending.
REQ-038 All registered outputs and internal state power up at the same values as after reset.

Configuration
REQ-039 MEM_TIMEOUT_EN defined: a 4-bit counter increments on each cycle spent in WAIT and clears on leaving WAIT; at count 15 the FSM goes to DONE, the buffer is loaded with 32'hDEADBEEF, and Mem_Err is set to 1 and held until Rst.
REQ-040 MEM_TIMEOUT_EN undefined: no counter exists, WAIT persists until D_Ack arrives, and Mem_Err is tied to 0.

Verification
REQ-041 lw with M_ALUout=0x10, D_Ack returned in the request cycle -> Stall=1 for 1 cycle, D_Addr=0x10, D_We=0; on the next edge W_Data=D_Rdata, W_RegWr=1, W_Rw=M_Rw.
REQ-042 sw with M_busB=0xA5A5A5A5, D_Ack returned 3 cycles after the request -> Stall=1 for 4 cycles, D_We=1 throughout, W_RegWr=0 during the stall.
REQ-043 beq with M_Zero=1, M_Btarg=0x40 -> PCSrc=1 and PC_targ=0x40 in the same cycle; with M_Zero=0 -> PCSrc=0.
REQ-044 add with M_Overflow=1, M_RegWr=1 -> D_Req=0, Stall=0, W_RegWr=0.
REQ-045 Rst asserted while the FSM is in WAIT -> after the edge: state IDLE, W_RegWr=0, Mem_Err=0; a subsequent D_Ack is ignored.
REQ-046 MEM_TIMEOUT_EN defined, lw with D_Ack never asserted -> Stall released after 16 cycles, W_Data=0xDEADBEEF, Mem_Err=1 held until Rst.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_stage_if;
  logic [31:0] D_Addr;
  logic [31:0] D_Wdata;
  logic        D_We;
  logic        D_Req;
  logic [31:0] D_Rdata;
  logic        D_Ack;

  modport master (
    output D_Addr, D_Wdata, D_We, D_Req,
    input  D_Rdata, D_Ack
  );

  modport slave (
    input  D_Addr, D_Wdata, D_We, D_Req,
    output D_Rdata, D_Ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM, pipeline stall, branch/jump redirect, MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog that raises a sticky Mem_Err.
//
// state | meaning
// IDLE  | no access outstanding; a pending load/store issues its request here
// WAIT  | request held, waiting for D_Ack
// DONE  | access complete; stall released for one cycle
module mem_stage (
  input  logic        CLK,
  input  logic        Rst,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_busB,
  input  logic [31:0] M_Btarg,
  input  logic [31:0] M_Jtarg,
  input  logic        M_Zero,
  input  logic        M_Overflow,
  input  logic [4:0]  M_Rw,
  input  logic        M_MemWr,
  input  logic        M_Jump,
  input  logic        M_Branch,
  input  logic        M_MemtoReg,
  input  logic        M_RegWr,
  mem_stage_if.master dmem,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] PC_targ,
  output logic [31:0] W_Data,
  output logic [4:0]  W_Rw,
  output logic        W_RegWr,
  output logic        Mem_Err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Declaration initialisers give the same power-up state as reset.
  logic [1:0]  r_state   = S_IDLE;
  logic [31:0] r_buf     = 32'd0;
  logic [31:0] r_w_data  = 32'd0;
  logic [4:0]  r_w_rw    = 5'd0;
  logic        r_w_regwr = 1'b0;

  logic [1:0]  w_next;
  logic        w_ld;
  logic        w_st;
  logic        w_op;
  logic        w_busy;
  logic        w_stall;
  logic        w_capture;
  logic        w_timeout;

  assign w_ld   = M_MemtoReg & M_RegWr & ~M_Overflow;
  assign w_st   = M_MemWr & ~M_Overflow;
  assign w_op   = w_ld | w_st;
  assign w_busy = (r_state == S_IDLE) | (r_state == S_WAIT);

  assign dmem.D_Req   = w_op & w_busy;
  assign dmem.D_We    = w_st & dmem.D_Req;
  assign dmem.D_Addr  = {M_ALUout[31:2], 2'b00};
  assign dmem.D_Wdata = M_busB;

  assign w_stall   = w_op & (r_state != S_DONE);
  assign w_capture = dmem.D_Ack & w_ld & w_busy;

  assign Stall   = w_stall;
  assign PCSrc   = ~w_stall & (M_Jump | (M_Branch & M_Zero));
  assign PC_targ = M_Jump ? M_Jtarg : M_Btarg;

  assign W_Data  = r_w_data;
  assign W_Rw    = r_w_rw;
  assign W_RegWr = r_w_regwr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_op) w_next = dmem.D_Ack ? S_DONE : S_WAIT;
      S_WAIT:  if (dmem.D_Ack | w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_buf     <= 32'd0;
      r_w_data  <= 32'd0;
      r_w_rw    <= 5'd0;
      r_w_regwr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture)
        r_buf <= dmem.D_Rdata;
      else if (w_timeout)
        r_buf <= 32'hDEADBEEF;
      // A stalled cycle pushes a bubble into MEM/WB but keeps its data fields.
      if (!w_stall) begin
        r_w_data  <= M_MemtoReg ? r_buf : M_ALUout;
        r_w_rw    <= M_Rw;
        r_w_regwr <= M_RegWr & ~M_Overflow;
      end else begin
        r_w_regwr <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [3:0] r_cnt     = 4'd0;
  logic       r_mem_err = 1'b0;

  // The watchdog fires as the count reaches 15, so a lost access stalls 16 cycles in total.
  assign w_timeout = (r_state == S_WAIT) & ~dmem.D_Ack & (r_cnt == 4'd14);
  assign Mem_Err   = r_mem_err;

  always_ff @(negedge CLK) begin
    if (Rst) begin
      r_cnt     <= 4'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_cnt + 4'd1 : 4'd0;
      if (w_timeout)
        r_mem_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign Mem_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; state updates on the falling edge, checks near the rising edge.
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] M_ALUout, M_busB, M_Btarg, M_Jtarg;
  logic        M_Zero, M_Overflow, M_MemWr, M_Jump, M_Branch, M_MemtoReg, M_RegWr;
  logic [4:0]  M_Rw;
  logic        Stall, PCSrc, W_RegWr, Mem_Err;
  logic [31:0] PC_targ, W_Data;
  logic [4:0]  W_Rw;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_stall;

  mem_stage_if u_if ();

  mem_stage dut (
    .CLK        (CLK),
    .Rst        (Rst),
    .M_ALUout   (M_ALUout),
    .M_busB     (M_busB),
    .M_Btarg    (M_Btarg),
    .M_Jtarg    (M_Jtarg),
    .M_Zero     (M_Zero),
    .M_Overflow (M_Overflow),
    .M_Rw       (M_Rw),
    .M_MemWr    (M_MemWr),
    .M_Jump     (M_Jump),
    .M_Branch   (M_Branch),
    .M_MemtoReg (M_MemtoReg),
    .M_RegWr    (M_RegWr),
    .dmem       (u_if),
    .Stall      (Stall),
    .PCSrc      (PCSrc),
    .PC_targ    (PC_targ),
    .W_Data     (W_Data),
    .W_Rw       (W_Rw),
    .W_RegWr    (W_RegWr),
    .Mem_Err    (Mem_Err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    M_ALUout = '0; M_busB = '0; M_Btarg = '0; M_Jtarg = '0;
    M_Zero = 1'b0; M_Overflow = 1'b0; M_MemWr = 1'b0; M_Jump = 1'b0;
    M_Branch = 1'b0; M_MemtoReg = 1'b0; M_RegWr = 1'b0; M_Rw = '0;
    u_if.D_Ack = 1'b0; u_if.D_Rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clr();
    Rst = 1'b1;
    cyc(); cyc();
    check("rst_wdata", W_Data, 32'h0);
    check("rst_wrw", {27'd0, W_Rw}, 32'h0);
    check("rst_regwr", {31'd0, W_RegWr}, 32'h0);
    check("rst_memerr", {31'd0, Mem_Err}, 32'h0);
    check("rst_req", {31'd0, u_if.D_Req}, 32'h0);
    check("rst_stall", {31'd0, Stall}, 32'h0);
    Rst = 1'b0;

    // load acknowledged in its request cycle
    cyc();
    M_ALUout = 32'h10; M_MemtoReg = 1'b1; M_RegWr = 1'b1; M_Rw = 5'd7;
    u_if.D_Ack = 1'b1; u_if.D_Rdata = 32'h12345678;
    #1;
    check("lw_stall", {31'd0, Stall}, 32'h1);
    check("lw_req", {31'd0, u_if.D_Req}, 32'h1);
    check("lw_addr", u_if.D_Addr, 32'h10);
    check("lw_we", {31'd0, u_if.D_We}, 32'h0);
    cyc();
    u_if.D_Ack = 1'b0; u_if.D_Rdata = '0;
    #1;
    check("lw_release", {31'd0, Stall}, 32'h0);
    check("lw_req_drop", {31'd0, u_if.D_Req}, 32'h0);
    cyc();
    check("lw_wdata", W_Data, 32'h12345678);
    check("lw_regwr", {31'd0, W_RegWr}, 32'h1);
    check("lw_wrw", {27'd0, W_Rw}, 32'd7);
    clr();

    // store acknowledged three cycles after the request
    cyc();
    M_MemWr = 1'b1; M_ALUout = 32'h2B; M_busB = 32'hA5A5A5A5; M_Rw = 5'd4;
    #1;
    check("sw_addr", u_if.D_Addr, 32'h28);
    check("sw_wdata", u_if.D_Wdata, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      u_if.D_Ack = (i == 3);
      #1;
      check("sw_stall", {31'd0, Stall}, 32'h1);
      check("sw_we", {31'd0, u_if.D_We}, 32'h1);
      check("sw_bubble", {31'd0, W_RegWr}, 32'h0);
    end
    cyc();
    u_if.D_Ack = 1'b0;
    #1;
    check("sw_release", {31'd0, Stall}, 32'h0);
    check("sw_req_drop", {31'd0, u_if.D_Req}, 32'h0);
    cyc();
    check("sw_wdata", W_Data, 32'h2B);
    check("sw_regwr", {31'd0, W_RegWr}, 32'h0);
    check("sw_wrw", {27'd0, W_Rw}, 32'd4);
    clr();

    // branch / jump redirect
    cyc();
    M_Branch = 1'b1; M_Zero = 1'b1; M_Btarg = 32'h40; M_Jtarg = 32'h80;
    #1;
    check("beq_taken", {31'd0, PCSrc}, 32'h1);
    check("beq_targ", PC_targ, 32'h40);
    M_Zero = 1'b0;
    #1;
    check("beq_not_taken", {31'd0, PCSrc}, 32'h0);
    M_Jump = 1'b1;
    #1;
    check("jump_prio", {31'd0, PCSrc}, 32'h1);
    check("jump_targ", PC_targ, 32'h80);
    clr();
    cyc();
    M_Jump = 1'b1; M_MemWr = 1'b1;
    #1;
    check("jump_stalled", {31'd0, PCSrc}, 32'h0);
    clr();

    // overflowing instruction: no access, no write
    cyc();
    M_Overflow = 1'b1; M_RegWr = 1'b1; M_MemtoReg = 1'b1; M_Rw = 5'd3; M_ALUout = 32'h55;
    #1;
    check("ovf_req", {31'd0, u_if.D_Req}, 32'h0);
    check("ovf_stall", {31'd0, Stall}, 32'h0);
    cyc();
    check("ovf_regwr", {31'd0, W_RegWr}, 32'h0);
    check("ovf_wdata_buf", W_Data, 32'h12345678);
    check("ovf_wrw", {27'd0, W_Rw}, 32'd3);
    clr();
    M_RegWr = 1'b1; M_ALUout = 32'h99; M_Rw = 5'd9;
    cyc();
    check("add_regwr", {31'd0, W_RegWr}, 32'h1);
    check("add_wdata", W_Data, 32'h99);
    check("add_wrw", {27'd0, W_Rw}, 32'd9);
    clr();

    // reset while waiting, then a late acknowledge
    cyc();
    M_MemtoReg = 1'b1; M_RegWr = 1'b1; M_ALUout = 32'h20; M_Rw = 5'd2;
    #1;
    cyc();
    check("wait_stall", {31'd0, Stall}, 32'h1);
    check("wait_req", {31'd0, u_if.D_Req}, 32'h1);
    Rst = 1'b1;
    clr();
    cyc();
    Rst = 1'b0;
    #1;
    check("rstw_stall", {31'd0, Stall}, 32'h0);
    check("rstw_req", {31'd0, u_if.D_Req}, 32'h0);
    check("rstw_regwr", {31'd0, W_RegWr}, 32'h0);
    check("rstw_memerr", {31'd0, Mem_Err}, 32'h0);
    check("rstw_wdata", W_Data, 32'h0);
    u_if.D_Ack = 1'b1; u_if.D_Rdata = 32'hCAFEF00D;
    cyc();
    u_if.D_Ack = 1'b0;
    #1;
    check("late_ack_req", {31'd0, u_if.D_Req}, 32'h0);
    check("late_ack_stall", {31'd0, Stall}, 32'h0);
    M_Overflow = 1'b1; M_MemtoReg = 1'b1; M_RegWr = 1'b1; M_Rw = 5'd6;
    cyc();
    check("late_ack_buf", W_Data, 32'h0);
    check("late_ack_regwr", {31'd0, W_RegWr}, 32'h0);
    check("late_ack_wrw", {27'd0, W_Rw}, 32'd6);
    clr();

    // load with no acknowledge
    cyc();
    M_MemtoReg = 1'b1; M_RegWr = 1'b1; M_ALUout = 32'h30; M_Rw = 5'd12;
    #1;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      if (Stall !== 1'b1) break;
      n_stall++;
      cyc();
    end
`ifdef MEM_TIMEOUT_EN
    check("to_stall_len", n_stall, 32'd16);
    cyc();
    check("to_wdata", W_Data, 32'hDEADBEEF);
    check("to_regwr", {31'd0, W_RegWr}, 32'h1);
    check("to_wrw", {27'd0, W_Rw}, 32'd12);
    check("to_memerr", {31'd0, Mem_Err}, 32'h1);
    clr();
    cyc(); cyc();
    check("to_memerr_held", {31'd0, Mem_Err}, 32'h1);
    check("to_idle_req", {31'd0, u_if.D_Req}, 32'h0);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    #1;
    check("to_memerr_rst", {31'd0, Mem_Err}, 32'h0);
`else
    check("nto_stall_len", n_stall, 32'd40);
    check("nto_memerr", {31'd0, Mem_Err}, 32'h0);
    u_if.D_Ack = 1'b1; u_if.D_Rdata = 32'h0BADF00D;
    #1;
    check("nto_ack_stall", {31'd0, Stall}, 32'h1);
    cyc();
    u_if.D_Ack = 1'b0;
    #1;
    check("nto_release", {31'd0, Stall}, 32'h0);
    cyc();
    check("nto_wdata", W_Data, 32'h0BADF00D);
    check("nto_regwr", {31'd0, W_RegWr}, 32'h1);
    clr();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
